// File: rtl/mux_pkg.sv
// Shared types for the pipelined N:1 word selector: skid-buffer FSM states and select-width helper.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Select index width; a 1-bit select is the floor even for N_IN <= 2.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready skid buffer on a packed entry; in_ready depends on registered state only.
module skid_buf_2
  import mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] in_entry,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output state_e       state
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // valid never waits on ready, and held data stays stable until it transfers.
  state_e       state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_entry = main_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Parametrised N:1 word selector with a registered skid-buffered output stage.
// Define MUX_N_PIPE_ERR_CNT_EN to add the saturating err_cnt output.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int                WIDTH       = 32,
  parameter int                N_IN        = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
`ifdef MUX_N_PIPE_ERR_CNT_EN
  ,
  parameter int                ERR_CNT_W   = 8
`endif
  ,
  localparam int               SEL_W       = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_N_PIPE_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] src;
    logic             err;
  } entry_t;

  entry_t sel_entry, out_entry;
  state_e buf_state;

  // Selects past the last input yield DEFAULT_VAL with err set instead of aliasing.
  always_comb begin
    sel_entry.data = DEFAULT_VAL;
    sel_entry.src  = in_sel;
    sel_entry.err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_entry.data = in_data[k*WIDTH +: WIDTH];
        sel_entry.err  = 1'b0;
      end
    end
  end

  skid_buf_2 #(.W($bits(entry_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_entry  (sel_entry),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_entry (out_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state     (buf_state)
  );

  assign out_data = out_entry.data;
  assign out_src  = out_entry.src;
  assign out_err  = out_entry.err;

  a_handshake_from_state : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid == (buf_state != EMPTY)) && (in_ready == (buf_state != FULL)));

`ifdef MUX_N_PIPE_ERR_CNT_EN
  logic cnt_inc;
  assign cnt_inc = in_valid & in_ready & ~flush & sel_entry.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: DUT a is 8 inputs, DUT b is 6 inputs with DEFAULT_VAL 32'hDEAD_BEEF.
module tb_mux_n_pipe;

  localparam int W  = 32;
  localparam int SW = 3;
  localparam int EW = W + SW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [8*W-1:0] in_data_a;
  logic [SW-1:0]  in_sel_a, out_src_a;
  logic           in_valid_a, in_ready_a, out_err_a, out_valid_a, out_ready_a, flush_a;
  logic [W-1:0]   out_data_a;
  logic [6*W-1:0] in_data_b;
  logic [SW-1:0]  in_sel_b, out_src_b;
  logic           in_valid_b, in_ready_b, out_err_b, out_valid_b, out_ready_b, flush_b;
  logic [W-1:0]   out_data_b;
`ifdef MUX_N_PIPE_ERR_CNT_EN
  logic [7:0]     err_cnt_a;
  logic [1:0]     err_cnt_b;
`endif

  mux_n_pipe #(.WIDTH(W), .N_IN(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .in_data(in_data_a), .in_sel(in_sel_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a), .out_src(out_src_a),
    .out_err(out_err_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
`ifdef MUX_N_PIPE_ERR_CNT_EN
    , .err_cnt(err_cnt_a)
`endif
  );

  mux_n_pipe #(.WIDTH(W), .N_IN(6), .DEFAULT_VAL(32'hDEAD_BEEF)
`ifdef MUX_N_PIPE_ERR_CNT_EN
    , .ERR_CNT_W(2)
`endif
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_data(in_data_b), .in_sel(in_sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b), .out_src(out_src_b),
    .out_err(out_err_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
`ifdef MUX_N_PIPE_ERR_CNT_EN
    , .err_cnt(err_cnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  logic [EW-1:0] pend_a, pend_b, exp_a, exp_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [SW-1:0] sel, input logic [W-1:0] exp_d, input logic exp_e);
    in_valid_a = 1'b1;
    in_sel_a   = sel;
    pend_a     = {exp_d, sel, exp_e};
  endtask

  task automatic drive_b(input logic [SW-1:0] sel, input logic [W-1:0] exp_d, input logic exp_e);
    in_valid_b = 1'b1;
    in_sel_b   = sel;
    pend_b     = {exp_d, sel, exp_e};
  endtask

  // scoreboard: pop/compare on each output transfer, then push on each accepted input
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      if (out_valid_a && out_ready_a) begin
        checks++;
        if (exp_q_a.size() == 0) begin
          errors++;
          $display("FAIL a_beat: got unexpected %0h required none", {out_data_a, out_src_a, out_err_a});
        end else begin
          exp_a = exp_q_a.pop_front();
          if ({out_data_a, out_src_a, out_err_a} !== exp_a) begin
            errors++;
            $display("FAIL a_beat: got %0h expected %0h", {out_data_a, out_src_a, out_err_a}, exp_a);
          end
        end
      end
      if (flush_a) exp_q_a.delete();
      else if (in_valid_a && in_ready_a) exp_q_a.push_back(pend_a);

      if (out_valid_b && out_ready_b) begin
        checks++;
        if (exp_q_b.size() == 0) begin
          errors++;
          $display("FAIL b_beat: got unexpected %0h required none", {out_data_b, out_src_b, out_err_b});
        end else begin
          exp_b = exp_q_b.pop_front();
          if ({out_data_b, out_src_b, out_err_b} !== exp_b) begin
            errors++;
            $display("FAIL b_beat: got %0h expected %0h", {out_data_b, out_src_b, out_err_b}, exp_b);
          end
        end
      end
      if (flush_b) exp_q_b.delete();
      else if (in_valid_b && in_ready_b) exp_q_b.push_back(pend_b);
    end
  end

  logic [SW-1:0] b_sel_tab [4] = '{3'd7, 3'd6, 3'd5, 3'd0};
  logic [W-1:0]  b_dat_tab [4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2000_0005, 32'h2000_0000};
  logic          b_err_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`ifdef MUX_N_PIPE_ERR_CNT_EN
  logic [1:0]    cnt_tab   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif

  initial begin
    for (int k = 0; k < 8; k++) in_data_a[k*W +: W] = 32'h1000_0000 + k;
    for (int k = 0; k < 6; k++) in_data_b[k*W +: W] = 32'h2000_0000 + k;
    in_sel_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0; flush_a = 1'b0; pend_a = '0;
    in_sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0; flush_b = 1'b0; pend_b = '0;

    // reset values
    tick(); tick();
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_src", out_src_a, 0);
    chk("rst_out_err", out_err_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
`ifdef MUX_N_PIPE_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt_a, 0);
`endif
    rst_n = 1'b1;
    tick();

    // streaming, one beat per cycle, 1-cycle latency
    out_ready_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_a(SW'(k), 32'h1000_0000 + k, 1'b0);
      chk("stream_in_ready", in_ready_a, 1);
      tick();
      chk("stream_out_valid", out_valid_a, 1);
      chk("stream_out_data", out_data_a, 32'h1000_0000 + k);
      chk("stream_out_src", out_src_a, k);
    end
    in_valid_a = 1'b0;
    tick();
    chk("stream_drained", out_valid_a, 0);

    // backpressure: fill, hold a third beat off, then release
    out_ready_a = 1'b0;
    drive_a(3'd3, 32'h1000_0003, 1'b0); tick();
    drive_a(3'd5, 32'h1000_0005, 1'b0); tick();
    chk("bp_full_in_ready", in_ready_a, 0);
    drive_a(3'd6, 32'h1000_0006, 1'b0);
    tick(); tick();
    chk("bp_hold_data", out_data_a, 32'h1000_0003);
    chk("bp_hold_in_ready", in_ready_a, 0);
    chk("bp_hold_valid", out_valid_a, 1);
    out_ready_a = 1'b1;
    tick();
    chk("bp_ready_after_pop", in_ready_a, 1);
    chk("bp_second_data", out_data_a, 32'h1000_0005);
    tick();
    chk("bp_third_data", out_data_a, 32'h1000_0006);
    in_valid_a = 1'b0;
    tick();
    chk("bp_drained", out_valid_a, 0);

    // reset mid-operation while FULL
    out_ready_a = 1'b0;
    drive_a(3'd1, 32'h1000_0001, 1'b0); tick();
    drive_a(3'd2, 32'h1000_0002, 1'b0); tick();
    in_valid_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid_a, 0);
    chk("midrst_out_data", out_data_a, 0);
    chk("midrst_in_ready", in_ready_a, 1);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready_a = 1'b1;
    drive_a(3'd4, 32'h1000_0004, 1'b0); tick();
    chk("postrst_out_data", out_data_a, 32'h1000_0004);
    chk("postrst_out_valid", out_valid_a, 1);
    in_valid_a = 1'b0;
    tick();

    // flush while FULL with an input beat offered
    out_ready_a = 1'b0;
    drive_a(3'd0, 32'h1000_0000, 1'b0); tick();
    drive_a(3'd7, 32'h1000_0007, 1'b0); tick();
    drive_a(3'd2, 32'h1000_0002, 1'b0);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    in_valid_a = 1'b0;
    chk("flush_out_valid", out_valid_a, 0);
    chk("flush_in_ready", in_ready_a, 1);
    out_ready_a = 1'b1;
    repeat (3) tick();
    chk("flush_no_beat", out_valid_a, 0);

    // out-of-range selects on the 6-input instance
    out_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_b(b_sel_tab[i], b_dat_tab[i], b_err_tab[i]);
      tick();
      chk("oor_out_data", out_data_b, b_dat_tab[i]);
      chk("oor_out_err", out_err_b, b_err_tab[i]);
      chk("oor_out_src", out_src_b, b_sel_tab[i]);
    end
    in_valid_b = 1'b0;
    tick();

`ifdef MUX_N_PIPE_ERR_CNT_EN
    // saturating error count; flushed bad beat does not count
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    chk("cnt_after_rst", err_cnt_b, 0);
    drive_b(3'd7, 32'hDEAD_BEEF, 1'b1);
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0;
    chk("cnt_flushed", err_cnt_b, 0);
    for (int i = 0; i < 5; i++) begin
      drive_b(3'd7, 32'hDEAD_BEEF, 1'b1);
      tick();
      chk("cnt_sat", err_cnt_b, cnt_tab[i]);
    end
    in_valid_b = 1'b0;
    tick();
    chk("cnt_a_clean", err_cnt_a, 0);
`endif

    repeat (3) tick();
    chk("a_queue_drained", exp_q_a.size(), 0);
    chk("b_queue_drained", exp_q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
